myo_setpoint_ramp: RTL

//  Upstream stage of the MYO motor control block. Holds a target setpoint and a per-tick step limit per motor.
//  On each update tick it moves every motor's current setpoint one step toward its target.

---
 rtl/myo_setpoint_ramp.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/myo_setpoint_ramp.sv
// Setpoint ramp generator for the MYO motor block: slews each motor's setpoint toward its
// target by at most max_step per tick and emits every changed setpoint as a write transaction.
module myo_setpoint_ramp #(
   parameter int NUMBER_OF_MOTORS = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cfg_write,
   input  logic [1:0]  cfg_sel,
   input  logic [7:0]  cfg_motor,
   input  logic [31:0] cfg_data,
   input  logic        tick,
   output logic        sp_valid,
   input  logic        sp_ready,
   output logic [7:0]  sp_motor,
   output logic [31:0] sp_value,
   output logic        busy,
   output logic [15:0] overrun_count
);

   localparam int IW    = (NUMBER_OF_MOTORS > 1) ? $clog2(NUMBER_OF_MOTORS) : 1;
   localparam int DEPTH = 1 << IW;
   localparam logic [7:0]    NUM_MOTORS = 8'(NUMBER_OF_MOTORS);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUMBER_OF_MOTORS - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      EMIT
   } state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic          tick_pending;

   logic [31:0] target       [DEPTH];
   logic [31:0] current      [DEPTH];
   logic [15:0] max_step     [DEPTH];
   logic [31:0] last_emitted [DEPTH];

   logic [31:0]        cur_value;
   logic [31:0]        tgt_value;
   logic [15:0]        step_limit;
   logic signed [32:0] diff;
   logic signed [32:0] step;
   logic signed [32:0] delta;
   logic signed [32:0] sum;
   logic [31:0]        next_value;

   // Next setpoint for the motor under evaluation; the 33-bit difference cannot wrap at the extremes
   always_comb begin
      cur_value  = current[idx];
      tgt_value  = target[idx];
      step_limit = max_step[idx];
      diff       = {tgt_value[31], tgt_value} - {cur_value[31], cur_value};
      step       = {17'b0, step_limit};
      delta      = diff;
      sum        = '0;
      next_value = tgt_value;
      if (step_limit != 16'd0) begin
         if (diff > step)
            delta = step;
         else if (diff < -step)
            delta = -step;
         sum        = {cur_value[31], cur_value} + delta;
         next_value = sum[31:0];
      end
   end

   assign busy = (state != IDLE);

   // Sweep FSM, tick bookkeeping and configuration writes; a config write is placed last so it
   // wins over a sweep update to the same motor at the same edge
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         idx           <= '0;
         tick_pending  <= 1'b0;
         overrun_count <= '0;
         sp_valid      <= 1'b0;
         sp_motor      <= '0;
         sp_value      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            target[i]       <= '0;
            current[i]      <= '0;
            max_step[i]     <= '0;
            last_emitted[i] <= '0;
         end
      end else begin
         if (state != IDLE && tick) begin
            if (!tick_pending)
               tick_pending <= 1'b1;
            else if (overrun_count != 16'hFFFF)
               overrun_count <= overrun_count + 16'd1;
         end

         case (state)
            IDLE: begin
               if (tick || tick_pending) begin
                  tick_pending <= 1'b0;
                  idx          <= '0;
                  state        <= CALC;
               end
            end
            CALC: begin
               if (next_value != last_emitted[idx]) begin
                  current[idx] <= next_value;
                  sp_valid     <= 1'b1;
                  sp_motor     <= 8'(idx);
                  sp_value     <= next_value;
                  state        <= EMIT;
               end else if (idx == LAST_IDX) begin
                  state <= IDLE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            EMIT: begin
               if (sp_ready) begin
                  last_emitted[idx] <= sp_value;
                  sp_valid          <= 1'b0;
                  if (idx == LAST_IDX) begin
                     state <= IDLE;
                  end else begin
                     idx   <= idx + IW'(1);
                     state <= CALC;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (cfg_write && cfg_motor < NUM_MOTORS) begin
            case (cfg_sel)
               2'd0: target[cfg_motor[IW-1:0]] <= cfg_data;
               2'd1: max_step[cfg_motor[IW-1:0]] <= cfg_data[15:0];
               2'd2: begin
                  target[cfg_motor[IW-1:0]]  <= cfg_data;
                  current[cfg_motor[IW-1:0]] <= cfg_data;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
